// File: rtl/nios2_onchip_memory_arb_pkg.sv
// Shared types for the on-chip memory s2-port arbiter: FSM states, owner id
// and the tagged read-return entry.
package nios2_onchip_memory_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  function automatic arb_state_t grant_of(input owner_t o);
    return (o == OWNER_M1) ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/nios2_onchip_memory_arb_rdpipe.sv
// Tagged read-return shift register; DEPTH matches the memory read latency so
// the tag emerges in the same cycle as the corresponding readdata.
module nios2_onchip_memory_arb_rdpipe
  import nios2_onchip_memory_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t push,
  output rd_tag_t pop
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= push;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign pop = stage[DEPTH-1];

endmodule

// File: rtl/nios2_onchip_memory_arbiter.sv
// Two-master arbiter for the s2 port of the dual-port on-chip memory.
// NIOS2_ONCHIP_MEMORY_ARB_RR_EN selects round-robin IDLE tie-break (else master 0 priority).
module nios2_onchip_memory_arbiter
  import nios2_onchip_memory_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BE_W         = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_HOLD     = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address2,
  output logic [BE_W-1:0]   mem_byteenable2,
  output logic [DATA_W-1:0] mem_writedata2,
  output logic              mem_chipselect2,
  output logic              mem_write2,
  output logic              mem_clken2,
  input  logic [DATA_W-1:0] mem_readdata2
);

  localparam int unsigned     HC_W      = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  arb_state_t      state, state_nxt;
  logic [HC_W-1:0] hold_cnt;
  owner_t          last_grant;
  owner_t          owner;
  owner_t          tie_pick;
  logic            req0, req1;
  logic            accept;
  logic            owner_read, owner_write;
  rd_tag_t         rd_push, rd_pop;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef NIOS2_ONCHIP_MEMORY_ARB_RR_EN
  assign tie_pick = ~last_grant;
`else
  assign tie_pick = OWNER_M0;
`endif

  always_comb begin
    state_nxt      = state;
    owner          = last_grant;
    accept         = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = grant_of(tie_pick);
        else if (req0)    state_nxt = GRANT0;
        else if (req1)    state_nxt = GRANT1;
      end
      GRANT0: begin
        owner          = OWNER_M0;
        m0_waitrequest = 1'b0;
        accept         = req0;
        if (!req0)                             state_nxt = req1 ? GRANT1 : IDLE;
        else if (req1 && hold_cnt == HOLD_LAST) state_nxt = GRANT1;
      end
      GRANT1: begin
        owner          = OWNER_M1;
        m1_waitrequest = 1'b0;
        accept         = req1;
        if (!req1)                             state_nxt = req0 ? GRANT0 : IDLE;
        else if (req0 && hold_cnt == HOLD_LAST) state_nxt = GRANT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // In IDLE the mux keeps pointing at the last owner so the memory address bus stays quiet.
  always_comb begin
    if (owner == OWNER_M1) begin
      mem_address2    = m1_address;
      mem_byteenable2 = m1_byteenable;
      mem_writedata2  = m1_writedata;
      owner_read      = m1_read;
      owner_write     = m1_write;
    end else begin
      mem_address2    = m0_address;
      mem_byteenable2 = m0_byteenable;
      mem_writedata2  = m0_writedata;
      owner_read      = m0_read;
      owner_write     = m0_write;
    end
  end

  assign mem_chipselect2 = accept;
  assign mem_write2      = accept & owner_write;
  assign mem_clken2      = 1'b1;

  assign rd_push.valid = accept & owner_read & ~owner_write;
  assign rd_push.owner = owner;

  // hold_cnt saturates at MAX_HOLD-1 so a late-arriving competitor is served after the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_grant <= OWNER_M1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                  hold_cnt <= '0;
      else if (accept && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
      if (state_nxt == GRANT0)      last_grant <= OWNER_M0;
      else if (state_nxt == GRANT1) last_grant <= OWNER_M1;
    end
  end

  nios2_onchip_memory_arb_rdpipe #(
    .DEPTH(READ_LATENCY)
  ) u_rdpipe (
    .clk  (clk),
    .reset(reset),
    .push (rd_push),
    .pop  (rd_pop)
  );

  assign m0_readdata      = mem_readdata2;
  assign m1_readdata      = mem_readdata2;
  assign m0_readdatavalid = rd_pop.valid & (rd_pop.owner == OWNER_M0);
  assign m1_readdatavalid = rd_pop.valid & (rd_pop.owner == OWNER_M1);

endmodule

// File: tb/tb_nios2_onchip_memory_arbiter.sv
// Directed self-checking bench for nios2_onchip_memory_arbiter with a
// registered-address, unregistered-output memory model on the s2 port.
module tb_nios2_onchip_memory_arbiter;

`ifdef NIOS2_ONCHIP_MEMORY_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] mem_address2;
  logic [3:0]  mem_byteenable2;
  logic [31:0] mem_writedata2;
  logic        mem_chipselect2, mem_write2, mem_clken2;
  logic [31:0] mem_readdata2;

  int n_cmp = 0;
  int n_bad = 0;

  nios2_onchip_memory_arbiter #(
    .ADDR_W(16), .DATA_W(32), .BE_W(4), .READ_LATENCY(1), .MAX_HOLD(8)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address2(mem_address2), .mem_byteenable2(mem_byteenable2),
    .mem_writedata2(mem_writedata2), .mem_chipselect2(mem_chipselect2),
    .mem_write2(mem_write2), .mem_clken2(mem_clken2), .mem_readdata2(mem_readdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: address registered when selected, data read combinationally.
  logic [31:0] mem [0:65535];
  logic [15:0] addr_q;
  always @(posedge clk) begin
    if (reset) begin
      mem[16'h0010] <= 32'hDEADBEEF;
      mem[16'h0300] <= 32'h1111_0000;
      mem[16'h0301] <= 32'h2222_0001;
      mem[16'h0302] <= 32'h3333_0002;
      mem[16'h0400] <= 32'hFFFF_FFFF;
    end else if (mem_chipselect2 && mem_clken2) begin
      if (mem_write2)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable2[b]) mem[mem_address2][b*8 +: 8] <= mem_writedata2[b*8 +: 8];
      addr_q <= mem_address2;
    end
  end
  assign mem_readdata2 = mem[addr_q];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic idle_all();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
         mem_chipselect2, mem_write2, mem_clken2} !== 7'b1100001) begin
      n_bad++;
      $display("FAIL reset_outputs: got w0w1 rdv0rdv1 cs wr clken=%b%b %b%b %b %b %b required 11 00 0 0 1",
               m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
               mem_chipselect2, mem_write2, mem_clken2);
    end
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, mem_chipselect2} !== 3'b110) begin
      n_bad++;
      $display("FAIL post_reset_idle: got w0w1cs=%b%b%b required 110", m0_waitrequest, m1_waitrequest, mem_chipselect2);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_w [3];
    exp_w[0] = 2'b01;
    exp_w[1] = RR ? 2'b10 : 2'b01;
    exp_w[2] = 2'b01;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      m0_write = 1'b1; m1_write = 1'b1; m0_address = 16'h0050; m1_address = 16'h0060;
      #1;
      n_cmp++;
      if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
        n_bad++;
        $display("FAIL tie%0d_idle_bubble: got w0w1=%b%b required 11", t, m0_waitrequest, m1_waitrequest);
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({m0_waitrequest, m1_waitrequest} !== exp_w[t]) begin
        n_bad++;
        $display("FAIL tie%0d_winner: got w0w1=%b%b required %b", t, m0_waitrequest, m1_waitrequest, exp_w[t]);
      end
      @(negedge clk); idle_all(); #1;
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m0_read = 1'b1; m0_address = 16'h0010; m0_byteenable = 4'hF;
    #1;
    n_cmp++;
    if (m0_waitrequest !== 1'b1) begin
      n_bad++; $display("FAIL rd_idle_wait: got %b required 1", m0_waitrequest);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, mem_chipselect2, mem_write2} !== 4'b0110 ||
        mem_address2 !== 16'h0010) begin
      n_bad++;
      $display("FAIL rd_accept: got w0w1cswr=%b%b%b%b addr=%h required 0110 addr=0010",
               m0_waitrequest, m1_waitrequest, mem_chipselect2, mem_write2, mem_address2);
    end
    @(negedge clk); idle_all(); #1;
    n_cmp++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10 || m0_readdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rd_return: got rdv0rdv1=%b%b data=%h required 10 data=deadbeef",
               m0_readdatavalid, m1_readdatavalid, m0_readdata);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      n_bad++; $display("FAIL rd_single_pulse: got rdv0rdv1=%b%b required 00", m0_readdatavalid, m1_readdatavalid);
    end
  endtask

  task automatic test_stream_writes();
    logic [15:0] a0, a1;
    bit          first, exp_owner;
    a0 = 16'h0100; a1 = 16'h0200;
    first = RR;  // last grant before this tie went to master 0
    @(negedge clk);
    m0_write = 1'b1; m1_write = 1'b1; m0_address = a0; m1_address = a1;
    m0_writedata = {16'hA0A0, a0}; m1_writedata = {16'hB1B1, a1};
    #1;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
      n_bad++; $display("FAIL stream_bubble: got w0w1=%b%b required 11", m0_waitrequest, m1_waitrequest);
    end
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      m0_address = a0; m1_address = a1;
      m0_writedata = {16'hA0A0, a0}; m1_writedata = {16'hB1B1, a1};
      #1;
      exp_owner = first ^ (((c - 1) / 8) % 2 == 1);
      n_cmp++;
      if ({m0_waitrequest, m1_waitrequest} !== (exp_owner ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL stream_owner c%0d: got w0w1=%b%b required owner m%0d", c, m0_waitrequest, m1_waitrequest, exp_owner);
      end
      n_cmp++;
      if (mem_chipselect2 !== 1'b1 || mem_write2 !== 1'b1 || mem_address2 !== (exp_owner ? a1 : a0)) begin
        n_bad++;
        $display("FAIL stream_mem c%0d: got cs=%b wr=%b addr=%h required 1 1 %h", c,
                 mem_chipselect2, mem_write2, mem_address2, exp_owner ? a1 : a0);
      end
      if (exp_owner) a1++; else a0++;
    end
    @(negedge clk); idle_all(); #1;
  endtask

  task automatic test_read_then_switch();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h1111_0000; exp_d[1] = 32'h2222_0001; exp_d[2] = 32'h3333_0002;
    @(negedge clk);
    m0_read = 1'b1; m0_address = 16'h0300; #1;
    @(negedge clk);
    m1_write = 1'b1; m1_address = 16'h0310; m1_writedata = 32'h0BAD_F00D; #1;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
      n_bad++; $display("FAIL rs_first_accept: got w0w1=%b%b required 01", m0_waitrequest, m1_waitrequest);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) m0_address = 16'h0301 + 16'(i); else m0_read = 1'b0;
      #1;
      n_cmp++;
      if ({m0_readdatavalid, m1_readdatavalid, m1_waitrequest} !== 3'b101 || m0_readdata !== exp_d[i]) begin
        n_bad++;
        $display("FAIL rs_return%0d: got rdv0rdv1w1=%b%b%b data=%h required 101 data=%h", i,
                 m0_readdatavalid, m1_readdatavalid, m1_waitrequest, m0_readdata, exp_d[i]);
      end
    end
    n_cmp++;
    if (mem_chipselect2 !== 1'b0) begin
      n_bad++; $display("FAIL rs_no_access_on_release: got cs=%b required 0", mem_chipselect2);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, mem_chipselect2, mem_write2, m0_readdatavalid, m1_readdatavalid} !== 6'b101100 ||
        mem_address2 !== 16'h0310) begin
      n_bad++;
      $display("FAIL rs_m1_write: got w0w1cswr rdv0rdv1=%b%b%b%b %b%b addr=%h required 1011 00 addr=0310",
               m0_waitrequest, m1_waitrequest, mem_chipselect2, mem_write2, m0_readdatavalid, m1_readdatavalid, mem_address2);
    end
    @(negedge clk); idle_all(); #1;
  endtask

  task automatic test_byteenable();
    @(negedge clk);
    m1_write = 1'b1; m1_address = 16'h0400; m1_byteenable = 4'b0011; m1_writedata = 32'h1234_5678; #1;
    n_cmp++;
    if (m1_waitrequest !== 1'b1) begin
      n_bad++; $display("FAIL be_idle_wait: got %b required 1", m1_waitrequest);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({m1_waitrequest, mem_write2} !== 2'b01 || mem_byteenable2 !== 4'b0011) begin
      n_bad++;
      $display("FAIL be_write: got w1wr=%b%b be=%b required 01 be=0011", m1_waitrequest, mem_write2, mem_byteenable2);
    end
    @(negedge clk);
    m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 4'hF; #1;
    n_cmp++;
    if ({m1_waitrequest, mem_chipselect2, mem_write2} !== 3'b010) begin
      n_bad++;
      $display("FAIL be_read_accept: got w1cswr=%b%b%b required 010", m1_waitrequest, mem_chipselect2, mem_write2);
    end
    @(negedge clk); m1_read = 1'b0; #1;
    n_cmp++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== 32'hFFFF_5678) begin
      n_bad++;
      $display("FAIL be_readback: got rdv0rdv1=%b%b data=%h required 01 data=ffff5678",
               m0_readdatavalid, m1_readdatavalid, m1_readdata);
    end
    @(negedge clk); idle_all(); #1;
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    m0_read = 1'b1; m0_address = 16'h0010; #1;
    @(negedge clk); #1;
    n_cmp++;
    if (mem_chipselect2 !== 1'b1) begin
      n_bad++; $display("FAIL rst_read_accept: got cs=%b required 1", mem_chipselect2);
    end
    #1 reset = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({m0_waitrequest, m1_waitrequest, mem_chipselect2, m0_readdatavalid, m1_readdatavalid} !== 5'b11000) begin
        n_bad++;
        $display("FAIL rst_hold%0d: got w0w1 cs rdv0rdv1=%b%b %b %b%b required 11 0 00", i,
                 m0_waitrequest, m1_waitrequest, mem_chipselect2, m0_readdatavalid, m1_readdatavalid);
      end
      @(negedge clk); #1;
    end
    reset = 1'b0; idle_all(); #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 4'b1100) begin
        n_bad++;
        $display("FAIL rst_release%0d: got w0w1 rdv0rdv1=%b%b %b%b required 11 00", i,
                 m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid);
      end
      @(negedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_stream_writes();
    test_read_then_switch();
    test_byteenable();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
